// File: rtl/store_buffer_pkg.sv
// Shared definitions for the posted-write store buffer and the data memory
// controller FSM.
//   - M_IDLE / M_HI / M_LO : memory handshake state encodings
//   - SB_DEPTH             : default number of store entries
//   - ADDR_W/DATA_W/MASK_W : widths of the fields of one queued store
//   - sb_entry_t           : packed layout of one queued store {addr, data, mask}
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = 4;
  localparam int ENTRY_W = ADDR_W + DATA_W + MASK_W;

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_HI   = 2'd1;
  localparam logic [1:0] M_LO   = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } sb_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Circular FIFO holding the posted stores waiting to retire.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : write din at the tail (ignored while full)
//   pop, dout  : dout always shows the head; pop advances it (ignored while empty)
//   full/empty : occupancy flags derived from the entry count
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] slots_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               doPush;
  logic               doPop;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = slots_q[head_q];

  // Pointer and count bookkeeping. DEPTH is a power of two, so the pointers
  // wrap for free; a push and pop in the same cycle leave the count unchanged.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (doPush) tail_d = tail_q + 1'b1;
    if (doPop)  head_d = head_q + 1'b1;
    if (doPush && !doPop)      count_d = count_q + 1'b1;
    else if (doPop && !doPush) count_d = count_q - 1'b1;
  end

  // Reset discards every queued entry by zeroing the pointers and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: a slot is only read after it was pushed.
  always_ff @(posedge clk) begin
    if (doPush) slots_q[tail_q] <= din;
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the pipeline memory stage and the data memory.
// Stores are queued and retired in the background; loads wait until every
// queued store has retired, then issue, which keeps read-after-write order.
//   clk, reset                      : clock, asynchronous active-high reset
//   addr, write_data, sign_mask     : pipeline request fields
//   memwrite, memread               : pipeline store / load requests
//   read_data                       : registered load result
//   clk_stall                       : combinational freeze request to the pipeline
//   mem_addr, mem_write_data,
//   mem_sign_mask, mem_memwrite,
//   mem_memread                     : registered request to the data memory
//   mem_read_data, mem_clk_stall    : data memory read result and busy flag
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [MASK_W-1:0] sign_mask,
  output logic [DATA_W-1:0] read_data,
  output logic              clk_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [MASK_W-1:0] mem_sign_mask,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_clk_stall
);

  logic [1:0]        state_q, state_d;
  logic              isLoad_q, isLoad_d;
  logic              loadDone_q, loadDone_d;
  logic [DATA_W-1:0] readData_q, readData_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWData_q, memWData_d;
  logic [MASK_W-1:0] memMask_q, memMask_d;
  logic              memWrite_q, memWrite_d;
  logic              memRead_q, memRead_d;

  logic              fifoFull;
  logic              fifoEmpty;
  logic              fifoPop;
  logic [ENTRY_W-1:0] fifoDout;
  sb_entry_t         headEntry;
  sb_entry_t         pushEntry;

  assign pushEntry = '{addr: addr, data: write_data, mask: sign_mask};
  assign headEntry = sb_entry_t'(fifoDout);

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (memwrite),
    .pop   (fifoPop),
    .din   (pushEntry),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  // A load holds the pipeline until its result is back; a store only holds
  // it while the FIFO is full. Reset forces the stall low with everything else.
  assign clk_stall = ~reset & ((memread & ~loadDone_q) | (memwrite & fifoFull));

  assign read_data      = readData_q;
  assign mem_addr       = memAddr_q;
  assign mem_write_data = memWData_q;
  assign mem_sign_mask  = memMask_q;
  assign mem_memwrite   = memWrite_q;
  assign mem_memread    = memRead_q;

  // Memory handshake. Stores win over loads, so a load only issues once the
  // FIFO is empty. Strobes default low, so each request lasts one cycle. A
  // request finishes when the memory raises and then drops its stall. The
  // loadDone_q pulse keeps the still-asserted memread of a finished load from
  // re-issuing in the cycle its result is handed back.
  always_comb begin
    state_d    = state_q;
    isLoad_d   = isLoad_q;
    loadDone_d = 1'b0;
    readData_d = readData_q;
    memAddr_d  = memAddr_q;
    memWData_d = memWData_q;
    memMask_d  = memMask_q;
    memWrite_d = 1'b0;
    memRead_d  = 1'b0;
    fifoPop    = 1'b0;
    case (state_q)
      M_IDLE: begin
        if (!fifoEmpty) begin
          memAddr_d  = headEntry.addr;
          memWData_d = headEntry.data;
          memMask_d  = headEntry.mask;
          memWrite_d = 1'b1;
          isLoad_d   = 1'b0;
          state_d    = M_HI;
        end else if (memread && !loadDone_q) begin
          memAddr_d = addr;
          memMask_d = sign_mask;
          memRead_d = 1'b1;
          isLoad_d  = 1'b1;
          state_d   = M_HI;
        end
      end
      M_HI: begin
        if (mem_clk_stall) state_d = M_LO;
      end
      M_LO: begin
        if (!mem_clk_stall) begin
          if (isLoad_q) begin
            readData_d = mem_read_data;
            loadDone_d = 1'b1;
          end else begin
            fifoPop = 1'b1;
          end
          state_d = M_IDLE;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  // Reset abandons any in-flight transaction and clears every output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= M_IDLE;
      isLoad_q   <= 1'b0;
      loadDone_q <= 1'b0;
      readData_q <= '0;
      memAddr_q  <= '0;
      memWData_q <= '0;
      memMask_q  <= '0;
      memWrite_q <= 1'b0;
      memRead_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      isLoad_q   <= isLoad_d;
      loadDone_q <= loadDone_d;
      readData_q <= readData_d;
      memAddr_q  <= memAddr_d;
      memWData_q <= memWData_d;
      memMask_q  <= memMask_d;
      memWrite_q <= memWrite_d;
      memRead_q  <= memRead_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a data memory model with configurable
// busy time, a transaction-level reference (architectural memory, queue of
// pending stores) compared against the DUT every cycle, and directed
// scenarios with hand-computed latencies.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .addr           (addr),
    .write_data     (write_data),
    .memwrite       (memwrite),
    .memread        (memread),
    .sign_mask      (sign_mask),
    .read_data      (read_data),
    .clk_stall      (clk_stall),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVectors = 0;
  int nMiscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Data memory model: word-addressed, busy for one cycle per request plus an
  // optional extra number of cycles chosen by memStallMode.
  logic [31:0] memArr [8192] = '{default: 32'h0};
  logic        memPending;
  int          memBusy;
  int          memStallMode = 0;

  function automatic int pickExtra();
    if (memStallMode == 1) return 2;
    if (memStallMode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  assign mem_clk_stall = mem_memwrite | mem_memread | (memPending && memBusy != 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      memPending    <= 1'b0;
      memBusy       <= 0;
      mem_read_data <= 32'h0;
    end else if (mem_memwrite) begin
      memArr[mem_addr[14:2]] <= mem_write_data;
      memPending <= 1'b1;
      memBusy    <= pickExtra();
    end else if (mem_memread) begin
      mem_read_data <= memArr[mem_addr[14:2]];
      memPending <= 1'b1;
      memBusy    <= pickExtra();
    end else if (memPending) begin
      if (memBusy != 0) memBusy <= memBusy - 1;
      else              memPending <= 1'b0;
    end
  end

  // Reference model: architectural memory as the pipeline sees it, plus the
  // queue of accepted but not yet retired stores.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;
  typedef struct {
    int          cyc;
    logic [31:0] a;
  } wlog_t;

  ent_t        mq[$];
  wlog_t       wrLog[$];
  logic [31:0] archMem [8192] = '{default: 32'h0};
  logic [31:0] mLastRead = 32'h0;
  logic        mLoadDone = 1'b0;
  logic        inflightLoad = 1'b0;
  logic [31:0] loadAddrM = 32'h0;
  logic        prevStrobe = 1'b0;
  int          cycle = 0;
  int          rdCount = 0;

  initial begin
    forever begin
      logic        expStall;
      logic        strobeNow;
      logic        nextLoadDone;
      logic [31:0] expA, expD, expM;
      @(negedge clk);
      cycle++;
      if (reset) begin
        mq.delete();
        archMem      = memArr;
        mLastRead    = 32'h0;
        mLoadDone    = 1'b0;
        inflightLoad = 1'b0;
        prevStrobe   = 1'b0;
        continue;
      end
      expStall  = (memread && !mLoadDone) || (memwrite && mq.size() == DEPTH);
      strobeNow = mem_memwrite | mem_memread;
      checkOutput("clk_stall", 32'(clk_stall), 32'(expStall));
      checkOutput("read_data", read_data, mLastRead);
      checkOutput("strobe_exclusive", 32'(mem_memwrite & mem_memread), 32'h0);
      checkOutput("strobe_back_to_back", 32'(prevStrobe & strobeNow), 32'h0);
      if (mem_memwrite) begin
        wrLog.push_back('{cyc: cycle, a: mem_addr});
        expA = (mq.size() > 0) ? mq[0].a : 32'hBAD0_0000;
        expD = (mq.size() > 0) ? mq[0].d : 32'hBAD0_0000;
        expM = (mq.size() > 0) ? 32'(mq[0].m) : 32'hBAD0_0000;
        checkOutput("wr_addr", mem_addr, expA);
        checkOutput("wr_data", mem_write_data, expD);
        checkOutput("wr_mask", 32'(mem_sign_mask), expM);
        inflightLoad = 1'b0;
      end
      if (mem_memread) begin
        rdCount++;
        checkOutput("rd_pending_stores", 32'(mq.size()), 32'h0);
        checkOutput("rd_addr", mem_addr, addr);
        checkOutput("rd_mask", 32'(mem_sign_mask), 32'(sign_mask));
        inflightLoad = 1'b1;
        loadAddrM    = addr;
      end
      nextLoadDone = 1'b0;
      if (memPending && memBusy == 0 && !strobeNow) begin
        if (inflightLoad) begin
          mLastRead    = archMem[loadAddrM[14:2]];
          nextLoadDone = 1'b1;
        end else if (mq.size() > 0) begin
          void'(mq.pop_front());
        end
      end
      mLoadDone = nextLoadDone;
      if (memwrite && !expStall) begin
        mq.push_back('{a: addr, d: write_data, m: sign_mask});
        archMem[addr[14:2]] = write_data;
      end
      prevStrobe = strobeNow;
    end
  end

  // Present one pipeline request and hold it until the stall drops; report
  // the number of stalled cycles and the read_data seen when it completes.
  task automatic applyStimulus(input logic isWrite, input logic isRead,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] m,
                               output int stalls, output logic [31:0] rd);
    memwrite   = isWrite;
    memread    = isRead;
    addr       = a;
    write_data = d;
    sign_mask  = m;
    stalls     = 0;
    @(negedge clk);
    while (clk_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 200) checkOutput("request_timeout", 32'(clk_stall), 32'h0);
    rd = read_data;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    memread  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          st;
    logic [31:0] rd;
    int          base;
    int          rbase;
    logic [31:0] saved [10];
    int          expStalls [5];

    reset      = 1'b1;
    addr       = 32'h0;
    write_data = 32'h0;
    memwrite   = 1'b0;
    memread    = 1'b0;
    sign_mask  = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_read_data", read_data, 32'h0);
    checkOutput("reset_clk_stall", 32'(clk_stall), 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_mem_wdata", mem_write_data, 32'h0);
    checkOutput("reset_strobes", 32'({mem_memwrite, mem_memread}), 32'h0);
    checkOutput("reset_mem_mask", 32'(mem_sign_mask), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idleCycles(2);

    $display("[TB] four back-to-back stores");
    base = wrLog.size();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 4'h2, st, rd);
      checkOutput("store_no_stall", 32'(st), 32'h0);
    end
    idleCycles(15);
    checkOutput("four_store_pulses", 32'(wrLog.size() - base), 32'd4);
    if (wrLog.size() - base >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("fifo_order", wrLog[base + i].a, 32'h1000 + 32'(4 * i));
        if (i > 0) checkOutput("retire_spacing", 32'(wrLog[base + i].cyc - wrLog[base + i - 1].cyc), 32'd3);
      end
    end

    $display("[TB] five stores into a full buffer with a slow memory");
    memStallMode = 1;
    expStalls = '{0, 0, 0, 0, 2};
    base = wrLog.size();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h1100 + 32'(4 * i), $urandom, 4'h1, st, rd);
      checkOutput("full_store_stall", 32'(st), 32'(expStalls[i]));
    end
    idleCycles(60);
    checkOutput("five_store_pulses", 32'(wrLog.size() - base), 32'd5);
    memStallMode = 0;

    $display("[TB] store then dependent load");
    applyStimulus(1'b1, 1'b0, 32'h1010, 32'hDEADBEEF, 4'h2, st, rd);
    checkOutput("raw_store_stall", 32'(st), 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1010, 32'h0, 4'h2, st, rd);
    checkOutput("raw_load_stall", 32'(st), 32'd6);
    checkOutput("raw_load_data", rd, 32'hDEADBEEF);

    $display("[TB] two back-to-back loads");
    rbase = rdCount;
    applyStimulus(1'b0, 1'b1, 32'h1000, 32'h0, 4'h2, st, rd);
    checkOutput("load1_stall", 32'(st), 32'd3);
    checkOutput("load1_data", rd, 32'hA0);
    applyStimulus(1'b0, 1'b1, 32'h1004, 32'h0, 4'h2, st, rd);
    checkOutput("load2_stall", 32'(st), 32'd3);
    checkOutput("load2_data", rd, 32'hA1);
    idleCycles(3);
    checkOutput("load_pulse_count", 32'(rdCount - rbase), 32'd2);

    $display("[TB] reset during a retire");
    applyStimulus(1'b1, 1'b0, 32'h1200, 32'h11111111, 4'h2, st, rd);
    applyStimulus(1'b1, 1'b0, 32'h1204, 32'h22222222, 4'h2, st, rd);
    checkOutput("pre_reset_strobe", 32'(mem_memwrite), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_strobes", 32'({mem_memwrite, mem_memread}), 32'h0);
    checkOutput("mid_reset_mem_addr", mem_addr, 32'h0);
    checkOutput("mid_reset_mem_wdata", mem_write_data, 32'h0);
    checkOutput("mid_reset_mem_mask", 32'(mem_sign_mask), 32'h0);
    checkOutput("mid_reset_read_data", read_data, 32'h0);
    checkOutput("mid_reset_clk_stall", 32'(clk_stall), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    base = wrLog.size();
    idleCycles(12);
    checkOutput("post_reset_writes", 32'(wrLog.size() - base), 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1200, 32'h0, 4'h2, st, rd);
    checkOutput("discarded_load_stall", 32'(st), 32'd3);
    checkOutput("discarded_load_data", rd, 32'h0);

    $display("[TB] pointer wrap with interleaved drains");
    for (int i = 0; i < 10; i++) begin
      saved[i] = $urandom;
      applyStimulus(1'b1, 1'b0, 32'h3000 + 32'(4 * i), saved[i], 4'h2, st, rd);
      if (i % 3 == 2) idleCycles(4);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h3000 + 32'(4 * i), 32'h0, 4'h2, st, rd);
      checkOutput("wrap_load_data", rd, saved[i]);
    end

    $display("[TB] randomized traffic");
    memStallMode = 2;
    for (int n = 0; n < 250; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5)
        applyStimulus(1'b1, 1'b0, 32'h4000 + 32'(4 * $urandom_range(0, 7)), $urandom,
                      4'($urandom_range(0, 15)), st, rd);
      else if (r < 8)
        applyStimulus(1'b0, 1'b1, 32'h4000 + 32'(4 * $urandom_range(0, 7)), 32'h0,
                      4'($urandom_range(0, 15)), st, rd);
      else
        idleCycles(int'($urandom_range(1, 3)));
    end
    idleCycles(40);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
